slave_bus_state_sequencer: RTL and testbench

//  Sequences USB slave bus power state (detached/default/active/suspend/resume/remote-wakeup).

---
 rtl/slave_bus_state_sequencer_if.sv | 46 ++++
 rtl/slave_bus_state_sequencer.sv | 161 ++++++++++++++++
 tb/tb_slave_bus_state_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/slave_bus_state_sequencer_if.sv
// Bus-side signal bundle between the slave RX status monitor / slave control block
// and the USB slave bus power-state sequencer.
interface slave_bus_state_sequencer_if;
   logic [1:0] connectState;
   logic       resetEvent;
   logic       resumeInt;
   logic       busActivity;
   logic       remoteWakeupEn;
   logic       remoteWakeupReq;
   logic [2:0] busState;
   logic       suspendOut;
   logic       rwakeDriveK;
   logic       suspendIntOut;
   logic       resumeIntOut;
   logic       resetIntOut;

   modport master (
      output connectState,
      output resetEvent,
      output resumeInt,
      output busActivity,
      output remoteWakeupEn,
      output remoteWakeupReq,
      input  busState,
      input  suspendOut,
      input  rwakeDriveK,
      input  suspendIntOut,
      input  resumeIntOut,
      input  resetIntOut
   );

   modport slave (
      input  connectState,
      input  resetEvent,
      input  resumeInt,
      input  busActivity,
      input  remoteWakeupEn,
      input  remoteWakeupReq,
      output busState,
      output suspendOut,
      output rwakeDriveK,
      output suspendIntOut,
      output resumeIntOut,
      output resetIntOut
   );
endinterface

// File: rtl/slave_bus_state_sequencer.sv
// USB slave bus power-state sequencer: detached/default/active/suspend/resume/remote-wakeup,
// with idle-suspend detection, remote-wakeup K timing and one-cycle interrupt pulses.
module slave_bus_state_sequencer #(
   parameter int CNT_W            = 18,
   parameter int SUSPEND_TICKS    = 144000,
   parameter int RWAKE_IDLE_TICKS = 240000,
   parameter int RWAKE_TICKS      = 96000
) (
   input  logic                      clk,
   input  logic                      rst,
   slave_bus_state_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      ST_DETACHED    = 3'd0,
      ST_DEFAULT     = 3'd1,
      ST_ACTIVE      = 3'd2,
      ST_SUSPENDED   = 3'd3,
      ST_RWAKE_DRIVE = 3'd4,
      ST_RESUMING    = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] SUSPEND_LAST    = CNT_W'(SUSPEND_TICKS - 1);
   localparam logic [CNT_W-1:0] RWAKE_IDLE_LAST = CNT_W'(RWAKE_IDLE_TICKS - 1);
   localparam logic [CNT_W-1:0] RWAKE_LAST      = CNT_W'(RWAKE_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX         = '1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wake_pending_q, wake_pending_d;
   logic             seen_act_q, seen_act_d;
   logic             suspend_q, suspend_d;
   logic             rwake_q, rwake_d;
   logic             suspend_int_q, suspend_int_d;
   logic             resume_int_q, resume_int_d;
   logic             reset_int_q, reset_int_d;

   logic             attached;
   logic             reset_entry;
   logic             state_change;

   assign attached = (bus.connectState != 2'b00);

   // Next-state selection: detach beats bus reset, which beats every state-local rule.
   always_comb begin
      state_d     = state_q;
      reset_entry = 1'b0;
      if (!attached) begin
         state_d = ST_DETACHED;
      end else if (bus.resetEvent) begin
         state_d     = ST_DEFAULT;
         reset_entry = 1'b1;
      end else begin
         case (state_q)
            ST_DETACHED: begin
               state_d = ST_DEFAULT;
            end
            ST_DEFAULT: begin
               if (bus.busActivity) begin
                  state_d = ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (!bus.busActivity && (cnt_q == SUSPEND_LAST)) begin
                  state_d = ST_SUSPENDED;
               end
            end
            ST_SUSPENDED: begin
               if (bus.resumeInt || bus.busActivity) begin
                  state_d = ST_RESUMING;
               end else if (wake_pending_q && (cnt_q >= RWAKE_IDLE_LAST)) begin
                  state_d = ST_RWAKE_DRIVE;
               end
            end
            ST_RWAKE_DRIVE: begin
               // Line activity here is our own K, so it is deliberately ignored.
               if (cnt_q == RWAKE_LAST) begin
                  state_d = ST_RESUMING;
               end
            end
            ST_RESUMING: begin
               if (!bus.busActivity && seen_act_q) begin
                  state_d = ST_ACTIVE;
               end
            end
            default: begin
               state_d = ST_DETACHED;
            end
         endcase
      end
   end

   // A bus reset while already in DEFAULT is still a fresh entry.
   assign state_change = (state_d != state_q) || reset_entry;

   always_comb begin
      cnt_d = cnt_q;
      if (state_change || ((state_q == ST_ACTIVE) && bus.busActivity)) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      wake_pending_d = 1'b0;
      if ((state_q == ST_SUSPENDED) && !state_change) begin
         wake_pending_d = wake_pending_q || (bus.remoteWakeupReq && bus.remoteWakeupEn);
      end
   end

   always_comb begin
      seen_act_d = seen_act_q;
      if (state_change) begin
         seen_act_d = 1'b0;
      end else if ((state_q == ST_RESUMING) && bus.busActivity) begin
         seen_act_d = 1'b1;
      end
   end

   // Levels follow the next state so they line up with busState; pulses mark entries only.
   always_comb begin
      suspend_d     = (state_d == ST_SUSPENDED);
      rwake_d       = (state_d == ST_RWAKE_DRIVE);
      suspend_int_d = state_change && (state_d == ST_SUSPENDED);
      resume_int_d  = state_change && (state_d == ST_RESUMING);
      reset_int_d   = reset_entry;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= ST_DETACHED;
         cnt_q          <= '0;
         wake_pending_q <= 1'b0;
         seen_act_q     <= 1'b0;
         suspend_q      <= 1'b0;
         rwake_q        <= 1'b0;
         suspend_int_q  <= 1'b0;
         resume_int_q   <= 1'b0;
         reset_int_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         wake_pending_q <= wake_pending_d;
         seen_act_q     <= seen_act_d;
         suspend_q      <= suspend_d;
         rwake_q        <= rwake_d;
         suspend_int_q  <= suspend_int_d;
         resume_int_q   <= resume_int_d;
         reset_int_q    <= reset_int_d;
      end
   end

   assign bus.busState      = state_q;
   assign bus.suspendOut    = suspend_q;
   assign bus.rwakeDriveK   = rwake_q;
   assign bus.suspendIntOut = suspend_int_q;
   assign bus.resumeIntOut  = resume_int_q;
   assign bus.resetIntOut   = reset_int_q;

endmodule

// File: tb/tb_slave_bus_state_sequencer.sv
// Directed scoreboard bench for slave_bus_state_sequencer with shortened timer parameters.
module tb_slave_bus_state_sequencer;

   localparam int CNT_W = 18;
   localparam int SUS_T = 16;
   localparam int RWI_T = 8;
   localparam int RWK_T = 4;

   // Output bundle order: {suspendOut, rwakeDriveK, suspendIntOut, resumeIntOut, resetIntOut}
   localparam logic [4:0] O_NONE    = 5'b00000;
   localparam logic [4:0] O_SUS     = 5'b10000;
   localparam logic [4:0] O_SUS_INT = 5'b10100;
   localparam logic [4:0] O_RWK     = 5'b01000;
   localparam logic [4:0] O_RI      = 5'b00010;
   localparam logic [4:0] O_RST     = 5'b00001;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   slave_bus_state_sequencer_if bus_if ();

   slave_bus_state_sequencer #(
      .CNT_W            (CNT_W),
      .SUSPEND_TICKS    (SUS_T),
      .RWAKE_IDLE_TICKS (RWI_T),
      .RWAKE_TICKS      (RWK_T)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct {
      string      tag;
      logic [2:0] st;
      logic [4:0] outs;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One clock: queue expectation, advance, clear pulse inputs, then pop and compare.
   task automatic cyc(input string tag, input logic [2:0] st, input logic [4:0] outs);
      exp_t       e;
      exp_t       r;
      logic [4:0] got_outs;
      e.tag  = tag;
      e.st   = st;
      e.outs = outs;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      bus_if.resetEvent      = 1'b0;
      bus_if.resumeInt       = 1'b0;
      bus_if.remoteWakeupReq = 1'b0;
      r = sb_q.pop_front();
      got_outs = {bus_if.suspendOut, bus_if.rwakeDriveK, bus_if.suspendIntOut,
                  bus_if.resumeIntOut, bus_if.resetIntOut};
      check_eq({r.tag, ".state"}, 32'(bus_if.busState), 32'(r.st));
      check_eq({r.tag, ".outs"}, 32'(got_outs), 32'(r.outs));
      $display("txn %-14s state=%0d outs=%b exp_state=%0d exp_outs=%b",
               r.tag, bus_if.busState, got_outs, r.st, r.outs);
   endtask

   task automatic hold(input string tag, input int n, input logic [2:0] st, input logic [4:0] outs);
      for (int i = 0; i < n; i++) begin
         cyc(tag, st, outs);
      end
   endtask

   // From ACTIVE with the counter freshly cleared: SUS_T idle cycles reach SUSPENDED.
   task automatic go_suspend(input string tag);
      bus_if.busActivity = 1'b0;
      hold(tag, SUS_T - 1, 3'd2, O_NONE);
      cyc(tag, 3'd3, O_SUS_INT);
   endtask

   // In SUSPENDED with cnt=0: request at cnt 0, drive starts after the cnt=RWI_T-1 cycle.
   task automatic go_rwake(input string tag);
      bus_if.remoteWakeupEn  = 1'b1;
      bus_if.remoteWakeupReq = 1'b1;
      cyc(tag, 3'd3, O_SUS);
      hold(tag, RWI_T - 2, 3'd3, O_SUS);
      cyc(tag, 3'd4, O_RWK);
   endtask

   initial begin
      bus_if.connectState    = 2'b10;
      bus_if.resetEvent      = 1'b0;
      bus_if.resumeInt       = 1'b0;
      bus_if.busActivity     = 1'b0;
      bus_if.remoteWakeupEn  = 1'b0;
      bus_if.remoteWakeupReq = 1'b0;

      hold("reset", 3, 3'd0, O_NONE);
      rst = 1'b1;
      cyc("attach", 3'd1, O_NONE);
      bus_if.busActivity = 1'b1;
      cyc("active", 3'd2, O_NONE);
      cyc("active_hold", 3'd2, O_NONE);

      // Activity on idle cycle 15 restarts the suspend count
      bus_if.busActivity = 1'b0;
      hold("idle14", 14, 3'd2, O_NONE);
      bus_if.busActivity = 1'b1;
      cyc("act_c15", 3'd2, O_NONE);
      go_suspend("suspend1");
      cyc("susp_hold", 3'd3, O_SUS);

      // Host resume, then K/EOP back to ACTIVE
      bus_if.resumeInt = 1'b1;
      cyc("host_resume", 3'd5, O_RI);
      cyc("resume_wait", 3'd5, O_NONE);
      bus_if.busActivity = 1'b1;
      cyc("resume_k", 3'd5, O_NONE);
      bus_if.busActivity = 1'b0;
      cyc("resume_eop", 3'd2, O_NONE);

      // Remote wakeup enabled, request at cnt=2
      go_suspend("suspend2");
      bus_if.remoteWakeupEn = 1'b1;
      cyc("rw_c0", 3'd3, O_SUS);
      cyc("rw_c1", 3'd3, O_SUS);
      bus_if.remoteWakeupReq = 1'b1;
      cyc("rw_req", 3'd3, O_SUS);
      hold("rw_wait", 4, 3'd3, O_SUS);
      cyc("rw_start", 3'd4, O_RWK);
      bus_if.busActivity = 1'b1;
      hold("rw_drive", RWK_T - 1, 3'd4, O_RWK);
      cyc("rw_done", 3'd5, O_RI);
      cyc("rw_k", 3'd5, O_NONE);
      bus_if.busActivity = 1'b0;
      cyc("rw_eop", 3'd2, O_NONE);

      // Request while ACTIVE is ignored; request with En=0 is dropped
      hold("pre_idle", 5, 3'd2, O_NONE);
      bus_if.remoteWakeupEn  = 1'b1;
      bus_if.remoteWakeupReq = 1'b1;
      cyc("req_active", 3'd2, O_NONE);
      hold("pre_idle2", SUS_T - 7, 3'd2, O_NONE);
      cyc("suspend3", 3'd3, O_SUS_INT);
      bus_if.remoteWakeupEn = 1'b0;
      hold("dis_c0", 2, 3'd3, O_SUS);
      bus_if.remoteWakeupReq = 1'b1;
      cyc("req_dis", 3'd3, O_SUS);
      hold("no_wake", 12, 3'd3, O_SUS);

      // Pending wakeup loses to a host resume in the same cycle
      bus_if.remoteWakeupEn  = 1'b1;
      bus_if.remoteWakeupReq = 1'b1;
      cyc("req_late", 3'd3, O_SUS);
      bus_if.resumeInt = 1'b1;
      cyc("resume_beats", 3'd5, O_RI);
      bus_if.busActivity = 1'b1;
      cyc("resume_k2", 3'd5, O_NONE);
      bus_if.busActivity = 1'b0;
      cyc("resume_eop2", 3'd2, O_NONE);

      // Bus reset from SUSPENDED and from DEFAULT
      go_suspend("suspend4");
      bus_if.resetEvent = 1'b1;
      cyc("rst_evt_susp", 3'd1, O_RST);
      cyc("default_hold", 3'd1, O_NONE);
      bus_if.resetEvent = 1'b1;
      cyc("rst_evt_dflt", 3'd1, O_RST);

      // Bus reset from RWAKE_DRIVE
      bus_if.busActivity = 1'b1;
      cyc("act2", 3'd2, O_NONE);
      go_suspend("suspend5");
      go_rwake("rw2");
      cyc("rw2_drive", 3'd4, O_RWK);
      bus_if.resetEvent = 1'b1;
      cyc("rst_evt_rwk", 3'd1, O_RST);

      // Detach beats a same-cycle bus reset; reattach gives no pulse
      bus_if.connectState = 2'b00;
      bus_if.resetEvent   = 1'b1;
      cyc("detach_rst", 3'd0, O_NONE);
      bus_if.connectState = 2'b01;
      cyc("reattach_ls", 3'd1, O_NONE);

      // Reset asserted in the middle of RWAKE_DRIVE
      bus_if.busActivity = 1'b1;
      cyc("act3", 3'd2, O_NONE);
      go_suspend("suspend6");
      go_rwake("rw3");
      rst = 1'b0;
      cyc("rst_mid_rwk", 3'd0, O_NONE);
      cyc("rst_hold", 3'd0, O_NONE);
      rst = 1'b1;
      cyc("post_rst", 3'd1, O_NONE);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
